// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM state
// encoding, fault cause codes and the request legality check.
package lsu_pkg;

  // funct3 encodings for RV32I loads and stores
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_ILLEGAL  = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } lsu_cause_e;

  // Classify a request before any bus activity. An illegal encoding wins
  // over misalignment because the access size is meaningless in that case.
  function automatic lsu_cause_e check_request(input logic       is_load,
                                               input logic       is_store,
                                               input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
    logic legal;
    logic misaligned;
    legal = 1'b0;
    if (is_load != is_store) begin
      if (is_load) legal = funct3 inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU};
      else         legal = funct3 inside {LSU_B, LSU_H, LSU_W};
    end
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    if (!legal)     return CAUSE_ILLEGAL;
    if (misaligned) return CAUSE_MISALIGN;
    return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Selects the addressed byte/halfword of a memory word and sign- or
// zero-extends it. Purely combinational; also used by the writeback mux.
module lsu_load_format
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] raw_word,
  output logic [31:0] load_value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by extension according to the access type
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can leave it unassigned (latch).
    byte_sel   = raw_word[7:0];
    half_sel   = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
    load_value = raw_word;
    case (addr_lo)
      2'd1:    byte_sel = raw_word[15:8];
      2'd2:    byte_sel = raw_word[23:16];
      2'd3:    byte_sel = raw_word[31:24];
      default: byte_sel = raw_word[7:0];
    endcase
    case (funct3)
      LSU_B:   load_value = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU:  load_value = {24'h000000, byte_sel};
      LSU_H:   load_value = {{16{half_sel[15]}}, half_sel};
      LSU_HU:  load_value = {16'h0000, half_sel};
      default: load_value = raw_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: checks the request, runs one transfer on a
// valid/ready word bus with byte lanes, and returns formatted load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic        isLoad,
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  faultCause,
  output logic [31:0] loadData,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic [3:0]  memWMask,
  output logic        memRStrobe,
  output logic        memWStrobe,
  input  logic [31:0] memRData,
  input  logic        memReady
);

  lsu_state_e  state_q, state_d;
  lsu_cause_e  req_cause;
  lsu_cause_e  cause_q;
  logic        is_load_q, is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] store_data_q;
  logic [31:0] load_data_q;
  logic [7:0]  wait_cnt;
  logic        timeout_hit;
  logic        accept;
  logic [31:0] lane_data;
  logic [3:0]  lane_mask;
  logic [31:0] fmt_word;

  assign req_cause   = check_request(isLoad, isStore, funct3, address[1:0]);
  assign accept      = (state_q == ST_IDLE) && start;
  assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

  // State register
  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous here, so it is an ordinary branch inside the
    // clocked block rather than part of the sensitivity list.
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: a bad request skips the bus; REQ ends on ready or timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (req_cause != CAUSE_NONE) ? ST_DONE : ST_REQ;
      ST_REQ:  if (memReady || timeout_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture, wait counter, fault cause and registered load result
  always_ff @(posedge CLK) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (RESET) begin
      is_load_q    <= 1'b0;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= 32'h0;
      store_data_q <= 32'h0;
      cause_q      <= CAUSE_NONE;
      load_data_q  <= 32'h0;
      wait_cnt     <= 8'd0;
    end else begin
      if (accept) begin
        is_load_q    <= isLoad;
        is_store_q   <= isStore;
        funct3_q     <= funct3;
        addr_q       <= address;
        store_data_q <= storeData;
        cause_q      <= req_cause;
      end
      if (state_q == ST_REQ) begin
        wait_cnt <= wait_cnt + 8'd1;
        if (memReady) begin
          if (is_load_q) load_data_q <= fmt_word;
        end else if (timeout_hit) begin
          cause_q <= CAUSE_TIMEOUT;
        end
      end else begin
        wait_cnt <= 8'd0;
      end
    end
  end

  // Store lane replication and byte enables for the latched access size
  always_comb begin
    lane_data = store_data_q;
    lane_mask = 4'b1111;
    case (funct3_q)
      LSU_B: begin
        lane_data = {4{store_data_q[7:0]}};
        lane_mask = 4'b0001 << addr_q[1:0];
      end
      LSU_H: begin
        lane_data = {2{store_data_q[15:0]}};
        lane_mask = 4'b0011 << {addr_q[1], 1'b0};
      end
      default: begin
        lane_data = store_data_q;
        lane_mask = 4'b1111;
      end
    endcase
  end

  lsu_load_format u_load_format (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .raw_word   (memRData),
    .load_value (fmt_word)
  );

  assign busy       = (state_q == ST_REQ);
  assign done       = (state_q == ST_DONE);
  assign fault      = done && (cause_q != CAUSE_NONE);
  assign faultCause = done ? cause_q : CAUSE_NONE;
  assign loadData   = load_data_q;
  assign memAddr    = {addr_q[31:2], 2'b00};
  assign memWData   = lane_data;
  assign memWMask   = (busy && is_store_q) ? lane_mask : 4'b0000;
  assign memRStrobe = busy && is_load_q;
  assign memWStrobe = busy && is_store_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage unit of the multicycle RV32I core. It sits downstream of the ALU, consuming the effective address (rs1 + immediate) and the rs2 store data, and upstream of writeback, producing the formatted load result. It handles one load or store at a time: it checks alignment, drives a valid/ready word-wide data-memory bus with byte lanes, and sign- or zero-extends load data.

Parameters:
TIMEOUT, 16, number of cycles to wait for memReady before aborting with a bus fault (legal range 2..255)

Ports:
CLK  input  1  core clock
RESET  input  1  reset; one clock, synchronous, active-high
start  input  1  one-cycle request pulse from the core's memory state
isLoad  input  1  request is a load (opcode 0000011)
isStore  input  1  request is a store (opcode 0100011)
funct3  input  3  access size and signedness from the instruction
address  input  32  effective byte address from the ALU
storeData  input  32  rs2 value for stores
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle completion pulse
fault  output  1  valid with done: access aborted
faultCause  output  2  valid with fault: 01 misaligned, 10 illegal funct3 or isLoad==isStore, 11 timeout
loadData  output  32  extended load result, valid with done when there is no fault; holds its value until the next done
memAddr  output  32  word address {addr[31:2],2'b00}
memWData  output  32  lane-replicated store data
memWMask  output  4  byte-lane write enables
memRStrobe  output  1  read request
memWStrobe  output  1  write request
memRData  input  32  read data, valid when memReady is high
memReady  input  1  memory completes the transfer this cycle

Behaviour:
- Reset (RESET=1 at a CLK edge): state IDLE and every output 0, including loadData. Reset during REQ drops the strobes on the next cycle; no done pulse is produced.
- States: IDLE, REQ, DONE.
- IDLE: start latches isLoad, isStore, funct3, address and storeData.
  - If the access is illegal or misaligned, go to DONE with fault set and no bus activity.
  - Otherwise go to REQ.
  - start is ignored in any state other than IDLE.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Misaligned: halfword access with addr[0]=1; word access with addr[1:0]!=0. When both illegal and misaligned apply, illegal takes priority.
- REQ: memAddr, memWData, memWMask and the strobe are held stable. The transfer completes on the first cycle where strobe && memReady, then go to DONE.
  - A wait counter resets on entry to REQ. If TIMEOUT cycles in REQ pass without memReady, go to DONE with fault and cause 11.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE. The next start is accepted in the following IDLE cycle.
- Latency:
  - Memory with zero wait states: start at edge N, strobe during cycle N+1, done during cycle N+2.
  - Fault with no bus access: done during cycle N+1.
- Store lanes:
  - SB: byte replicated ×4; mask 0001<<addr[1:0].
  - SH: halfword replicated ×2; mask 0011<<{addr[1],1'b0}.
  - SW: mask 1111.
  - memWMask=0 for loads.
- Load format: memRData is registered on the completing cycle.
  - Byte select by addr[1:0], halfword select by addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU)
  - state encoding
  - faultCause codes
- One combinational sub-module, lsu_load_format: inputs funct3, addr[1:0] and raw word; output the extended 32-bit value. It is reused later by the core's writeback mux.

Test Plan:
- SW 0xDEADBEEF to 0x100, memReady tied high -> memAddr=0x100, memWMask=1111, memWData=0xDEADBEEF, done exactly 2 cycles after start, fault=0.
- SB 0x000000A5 to 0x203 -> memAddr=0x200, memWMask=1000, memWData=0xA5A5A5A5.
- memRData=0x80F0_7F01: LB at 0x...2 -> 0xFFFFFFF0; LBU at 0x...2 -> 0x000000F0; LH at 0x...2 -> 0xFFFF80F0; LHU at 0x...0 -> 0x00007F01.
- LW at 0x102 -> done one cycle after start, fault=1, cause 01, memRStrobe never asserted. Load with funct3=011 -> fault=1, cause 10.
- Memory with memReady held low and TIMEOUT=16 -> strobe held for 16 cycles, then done with fault=1, cause 11. Repeat with memReady raised after 5 wait cycles -> done with correct data and no fault. A start pulsed while busy is ignored.
- RESET asserted during REQ -> strobes and busy are 0 on the next cycle, no done pulse, and a fresh start afterwards completes normally.
